// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the serial pattern-detection run controller.
package seq_detect_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int LEN_W       = $clog2(DEF_MAX_LEN + 1);

  typedef logic [LEN_W-1:0] len_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_match_core.sv
// History shift register, fill counter and length-masked compare producing the Mealy hit.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W_P = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               qual,
  input  logic               overlap,
  input  logic               d,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W_P-1:0] len,
  output logic               hit
);

  logic [MAX_LEN-1:0] hist;
  logic [LEN_W_P-1:0] fill;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W_P:0]   fill_p1;
  logic               match;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    cand    = {hist[MAX_LEN-2:0], d};
    // fill >= len-1 written as fill+1 >= len so len=1 cannot underflow
    fill_p1 = {1'b0, fill} + (LEN_W_P + 1)'(1);
    match   = (((cand ^ pat) & mask) == '0) && (fill_p1 >= {1'b0, len});
    hit     = qual && match;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist <= '0;
      fill <= '0;
    end else if (qual) begin
      if (hit && !overlap) begin
        hist <= '0;
        fill <= '0;
      end else begin
        hist <= cand;
        if (fill != LEN_W_P'(MAX_LEN)) fill <= fill + LEN_W_P'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: latches pattern configuration on start, scans qualified serial bits and
// counts matches until the target count is reached or the run is aborted.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LEN_W_P = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W_P-1:0] cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               d_valid,
  input  logic               d,
  output logic               z,
  output logic               busy,
  output logic               done,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt,
  output state_t             state_dbg
);

  // d_valid is a one-way qualifier with no back-pressure: a bit is consumed on any
  // rising edge where d_valid=1 and the FSM is in SCAN; at all other times d is ignored.

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W_P-1:0] len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;
  logic               cfg_legal;
  logic               accept;
  logic               reject;
  logic               qual;
  logic               hit;
  logic               last_hit;

  seq_match_core #(
    .MAX_LEN (MAX_LEN),
    .LEN_W_P (LEN_W_P)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .qual    (qual),
    .overlap (ovl_q),
    .d       (d),
    .pat     (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_comb begin
    cfg_legal = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN) && (cfg_target != '0);
    accept    = (state == S_IDLE) && start && cfg_legal;
    reject    = (state == S_IDLE) && start && !cfg_legal;
    // abort masks qualification, so a coincident hit neither shows on z nor counts
    qual      = (state == S_SCAN) && d_valid && !abort;
    last_hit  = hit && ((match_cnt + CNT_W'(1)) == tgt_q);
    z         = hit;
    busy      = (state == S_SCAN);
    done      = (state == S_DONE);
    state_dbg = state;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (accept) state_n = S_SCAN;
      S_SCAN: begin
        if (abort)         state_n = S_IDLE;
        else if (last_hit) state_n = S_DONE;
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cfg_err   <= 1'b0;
      match_cnt <= '0;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      tgt_q     <= '0;
    end else begin
      state   <= state_n;
      cfg_err <= reject;
      if (accept) begin
        pat_q     <= cfg_pattern;
        len_q     <= cfg_len;
        ovl_q     <= cfg_overlap;
        tgt_q     <= cfg_target;
        match_cnt <= '0;
      end else if (hit) begin
        match_cnt <= match_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed self-checking bench for seq_detect_ctrl: overlap/non-overlap scans, termination,
// illegal configuration, d_valid gaps, abort on a hit and mid-run reset.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               abort;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic [CNT_W-1:0]   cfg_target;
  logic               d_valid;
  logic               d;
  logic               z;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_cnt;
  state_t             state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [0:0] exp_q[$];

  // 101101 style test stream, first bit is the MSB
  localparam logic [13:0] STREAM   = 14'b10110011010101;
  localparam logic [13:0] Z_OVL    = 14'b00100000010101;
  localparam logic [13:0] Z_NOOVL  = 14'b00100000010001;
  localparam logic [13:0] Z_TGT2   = 14'b00100000010000;

  seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_target  (cfg_target),
    .d_valid     (d_valid),
    .d           (d),
    .z           (z),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err),
    .match_cnt   (match_cnt),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // all drivers operate from a falling edge and return on a falling edge
  task automatic do_start(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l,
                          input logic ovl, input logic [CNT_W-1:0] t);
    cfg_pattern = p; cfg_len = l; cfg_overlap = ovl; cfg_target = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_pattern = '1; cfg_len = LW'(1); cfg_overlap = ~ovl; cfg_target = CNT_W'(1);
  endtask

  task automatic send_bit(input logic b, input logic ab, input string tag);
    logic [0:0] ez;
    ez = exp_q.pop_front();
    d_valid = 1'b1; d = b; abort = ab;
    #1 chk(tag, 32'(z), 32'(ez));
    @(negedge clk);
    d_valid = 1'b0; d = 1'b1; abort = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      d_valid = 1'b0; d = 1'b1;
      #1 chk("z_idle", 32'(z), 32'd0);
      @(negedge clk);
    end
  endtask

  task automatic run_stream(input logic [13:0] zmask, input int nbits, input string tag);
    for (int i = 0; i < nbits; i++) exp_q.push_back(zmask[13-i]);
    for (int i = 0; i < nbits; i++) send_bit(STREAM[13-i], 1'b0, tag);
  endtask

  task automatic do_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; d_valid = 1'b0; d = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_target = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("rst_cnt", 32'(match_cnt), 32'd0);
    chk("rst_z", 32'(z), 32'd0);

    // overlapping 101, target never reached
    do_start(8'b101, LW'(3), 1'b1, CNT_W'(15));
    chk("ovl_busy", 32'(busy), 32'd1);
    run_stream(Z_OVL, 14, "ovl_z");
    chk("ovl_cnt", 32'(match_cnt), 32'd4);
    do_abort();
    chk("ovl_abort_busy", 32'(busy), 32'd0);
    chk("ovl_abort_cnt_hold", 32'(match_cnt), 32'd4);

    // non-overlapping 101
    do_start(8'b101, LW'(3), 1'b0, CNT_W'(15));
    chk("noovl_cnt_clr", 32'(match_cnt), 32'd0);
    run_stream(Z_NOOVL, 14, "noovl_z");
    chk("noovl_cnt", 32'(match_cnt), 32'd3);
    do_abort();

    // termination at target=2 after bit 10
    do_start(8'b101, LW'(3), 1'b1, CNT_W'(2));
    run_stream(Z_TGT2, 10, "tgt_z");
    chk("tgt_done", 32'(done), 32'd1);
    chk("tgt_busy", 32'(busy), 32'd0);
    chk("tgt_state", 32'(state_dbg), 32'(S_DONE));
    chk("tgt_cnt", 32'(match_cnt), 32'd2);
    for (int i = 0; i < 4; i++) exp_q.push_back(1'b0);
    send_bit(STREAM[3], 1'b0, "tgt_post_z");
    chk("tgt_done_pulse", 32'(done), 32'd0);
    chk("tgt_idle", 32'(state_dbg), 32'(S_IDLE));
    send_bit(STREAM[2], 1'b0, "tgt_post_z");
    send_bit(STREAM[1], 1'b0, "tgt_post_z");
    send_bit(STREAM[0], 1'b0, "tgt_post_z");
    chk("tgt_cnt_hold", 32'(match_cnt), 32'd2);

    // illegal configurations
    do_start(8'b101, LW'(0), 1'b1, CNT_W'(5));
    chk("err_len0", 32'(cfg_err), 32'd1);
    chk("err_len0_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("err_pulse", 32'(cfg_err), 32'd0);
    do_start(8'b101, LW'(3), 1'b1, CNT_W'(0));
    chk("err_tgt0", 32'(cfg_err), 32'd1);
    chk("err_tgt0_busy", 32'(busy), 32'd0);
    do_start(8'b101, LW'(9), 1'b1, CNT_W'(3));
    chk("err_len9", 32'(cfg_err), 32'd1);
    chk("err_cnt_hold", 32'(match_cnt), 32'd2);
    @(negedge clk);

    // d_valid gaps; d=1 during gaps would break the match if hist shifted
    do_start(8'b101, LW'(3), 1'b1, CNT_W'(15));
    exp_q.push_back(1'b0); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    send_bit(1'b1, 1'b0, "gap_z");
    idle_cycles(2);
    send_bit(1'b0, 1'b0, "gap_z");
    idle_cycles(3);
    send_bit(1'b1, 1'b0, "gap_z");
    chk("gap_cnt", 32'(match_cnt), 32'd1);

    // abort coincident with a hit (history ends 101, so 0 then 1 would hit)
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    send_bit(1'b0, 1'b0, "pre_abort_z");
    send_bit(1'b1, 1'b1, "abort_hit_z");
    chk("abort_cnt", 32'(match_cnt), 32'd1);
    chk("abort_state", 32'(state_dbg), 32'(S_IDLE));
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    // start during SCAN is dropped; then reset mid-run
    do_start(8'b1101, LW'(4), 1'b1, CNT_W'(9));
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    send_bit(1'b1, 1'b0, "rst_run_z");
    start = 1'b1; cfg_target = CNT_W'(1);
    send_bit(1'b1, 1'b0, "rst_run_z");
    start = 1'b0;
    chk("scan_start_ignored", 32'(state_dbg), 32'(S_SCAN));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_state", 32'(state_dbg), 32'(S_IDLE));
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_cfg_err", 32'(cfg_err), 32'd0);
    chk("mid_rst_cnt", 32'(match_cnt), 32'd0);
    chk("mid_rst_z", 32'(z), 32'd0);

    // len=1 boundary: every 1 matches, target 3 ends the run
    do_start(8'b1, LW'(1), 1'b0, CNT_W'(3));
    exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b1);
    send_bit(1'b1, 1'b0, "len1_z");
    send_bit(1'b0, 1'b0, "len1_z");
    send_bit(1'b1, 1'b0, "len1_z");
    send_bit(1'b1, 1'b0, "len1_z");
    chk("len1_done", 32'(done), 32'd1);
    chk("len1_cnt", 32'(match_cnt), 32'd3);
    @(negedge clk);
    chk("len1_idle", 32'(state_dbg), 32'(S_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run controller for the serial pattern-detection path. It latches a programmable pattern of up to MAX_LEN bits, a length, an overlap mode and a target match count. It then scans a qualified serial bit stream with a Mealy-style match output, counting matches until the target is reached or software aborts. It sits between the configuration/control interface and the serial input. It generalises the fixed 101 detector into a configurable, count-terminated run.

## Interface
- MAX_LEN, default 8: maximum pattern length in bits.
- CNT_W, default 8: width of the target and match counters.
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a run; ignored unless the FSM is in IDLE.
- abort  input  1  ends a run in SCAN without asserting done.
- cfg_pattern  input  MAX_LEN  pattern bits; bit [cfg_len-1] is the oldest bit, bit [0] the newest.
- cfg_len  input  $clog2(MAX_LEN+1)  pattern length; legal range 1..MAX_LEN.
- cfg_overlap  input  1  1 = overlapping matches allowed; 0 = history is cleared after each match.
- cfg_target  input  CNT_W  number of matches that ends the run; must be nonzero.
- d_valid  input  1  qualifies d for the current cycle.
- d  input  1  serial data bit.
- z  output  1  Mealy match flag; combinational, asserted in the same cycle as the completing bit.
- busy  output  1  high while the FSM is in SCAN.
- done  output  1  one-cycle pulse when the target count is reached.
- cfg_err  output  1  one-cycle pulse when start is rejected because of illegal configuration.
- match_cnt  output  CNT_W  matches counted in the current or most recent run.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE, start with legal config:
  - latch cfg_* into internal registers;
  - clear history, fill count and match_cnt;
  - go to SCAN.
- IDLE, start with illegal config (cfg_len==0, cfg_len>MAX_LEN or cfg_target==0):
  - pulse cfg_err;
  - stay in IDLE; match_cnt is unchanged.
- SCAN, d_valid=1:
  - candidate = {hist[len-2:0], d};
  - hit = candidate[len-1:0] == pat[len-1:0] && fill >= len-1;
  - z = hit, combinationally.
- SCAN, on the clock edge with d_valid=1:
  - hist shifts d in; fill increments, saturating at MAX_LEN;
  - if hit: match_cnt increments;
  - if hit and the overlap latch is 0: clear hist and fill;
  - if hit and match_cnt+1 == target: go to DONE.
- SCAN with d_valid=0: hist, fill and match_cnt hold; z=0.
- abort in SCAN: go to IDLE next edge; abort takes priority.
  - z is masked in that cycle;
  - a coincident hit is not counted;
  - done is not asserted.
- DONE: done=1 for exactly one cycle, then IDLE. d is ignored in DONE.
- z is 0 in every state other than SCAN.
- cfg_* are sampled only at an accepted start; changes during a run have no effect.
- match_cnt holds its value in IDLE until the next accepted start.
- Counter arithmetic is unsigned CNT_W. The counter cannot wrap, because the run terminates at target ≤ 2^CNT_W−1.

## Timing
- Reset values: FSM=IDLE; z=0, busy=0, done=0, cfg_err=0, match_cnt=0; hist and fill cleared.
- Reset mid-run returns the block to IDLE on the next edge. No done or cfg_err pulse is generated.
- Start is accepted at edge T. busy=1 from T+1. The first bit is sampled in the cycle after T.
- z has zero latency: it is valid in the same cycle as the completing d.
- match_cnt reflects a hit from the edge that ends the hit cycle.
- The final hit is at cycle H. The FSM is in DONE and done=1 during H+1, busy=0 during H+1, and the FSM is back in IDLE at H+2.
- Start asserted during SCAN or DONE is dropped; it is not queued.
- cfg_err is asserted in the cycle after the rejected start.

## Structure
- Package seq_detect_pkg holds:
  - the state enumeration typedef (IDLE, SCAN, DONE);
  - the default MAX_LEN and CNT_W values;
  - a len_t width constant.
- Sub-module seq_match_core is natural. It holds the history shift register, the fill counter and the combinational masked compare, and produces hit. The FSM, counter and configuration latches remain in seq_detect_ctrl.

## Test plan
- Overlap 101 (pat=3'b101, len=3, overlap=1, target=15). Stream, every bit with d_valid: 1,0,1,1,0,0,1,1,0,1,0,1,0,1.
  - Required: z high on bits 3, 10, 12 and 14; match_cnt=4.
- Non-overlap 101, same stream.
  - Required: z on bits 3, 10 and 14 only; match_cnt=3.
- Termination: overlap 101 with target=2, same stream.
  - Required: done pulses one cycle after bit 10; busy falls with it; later bits produce no z.
- Illegal config: start with cfg_len=0, then start with target=0.
  - Required: cfg_err pulses each time; busy stays 0.
- d_valid gaps: stream 1,0,1 with idle cycles between bits.
  - Required: one match; hist does not shift in idle cycles.
- Abort coincident with a hit, and rst asserted mid-SCAN.
  - Required: no count increment; z=0 in the abort cycle; no done; IDLE next cycle; all outputs at reset values.
